// File: rtl/md_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// default cycle counts and the op decode helper.
package md_unit_pkg;

    typedef enum logic [3:0] {
        HYLO_NONE  = 4'd0,
        HYLO_MULT  = 4'd1,
        HYLO_MULTU = 4'd2,
        HYLO_DIV   = 4'd3,
        HYLO_DIVU  = 4'd4,
        HYLO_MFHI  = 4'd5,
        HYLO_MFLO  = 4'd6,
        HYLO_MTHI  = 4'd7,
        HYLO_MTLO  = 4'd8
    } hylo_op_e;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the arithmetic unit for several cycles.
    function automatic logic is_md_op(input logic [3:0] op);
        logic res;
        case (op)
            HYLO_MULT, HYLO_MULTU, HYLO_DIV, HYLO_DIVU: res = 1'b1;
            default:                                    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage to md_unit connection. With MDU_DIV0_TRAP_EN defined the bundle also
// carries the divZero pulse.
interface md_unit_if;
    import md_unit_pkg::*;

    logic [3:0]  hyloOp;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        excCancel;
    logic        start;
    logic        busy;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic [31:0] mdOut;
`ifdef MDU_DIV0_TRAP_EN
    logic        divZero;
`endif

    modport master (
`ifdef MDU_DIV0_TRAP_EN
        input  divZero,
`endif
        output hyloOp, rsData, rtData, excCancel,
        input  start, busy, hiOut, loOut, mdOut
    );

    modport slave (
`ifdef MDU_DIV0_TRAP_EN
        output divZero,
`endif
        input  hyloOp, rsData, rtData, excCancel,
        output start, busy, hiOut, loOut, mdOut
    );

endinterface

// File: rtl/md_unit_arith.sv
// Combinational multiply/divide core (module md_arith). Signed division works
// on magnitudes so 0x80000000 / -1 and divide-by-zero stay well defined.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic signed [63:0] sa_s;
    logic signed [63:0] sb_s;
    logic [63:0]        sprod_s;
    logic [63:0]        uprod_s;
    logic [31:0]        a_mag_s;
    logic [31:0]        b_mag_s;
    logic [31:0]        sdiv_s;
    logic [31:0]        udiv_s;
    logic [31:0]        sq_s;
    logic [31:0]        sr_s;
    logic [31:0]        uq_s;
    logic [31:0]        ur_s;

    // Products, magnitudes and quotient/remainder for both signednesses.
    always_comb begin
        sa_s    = {{32{a[31]}}, a};
        sb_s    = {{32{b[31]}}, b};
        sprod_s = sa_s * sb_s;
        uprod_s = {32'd0, a} * {32'd0, b};
        a_mag_s = a[31] ? (32'd0 - a) : a;
        b_mag_s = b[31] ? (32'd0 - b) : b;
        // A zero divisor is replaced by one; the caller discards that result.
        sdiv_s  = (b == 32'd0) ? 32'd1 : b_mag_s;
        udiv_s  = (b == 32'd0) ? 32'd1 : b;
        sq_s    = a_mag_s / sdiv_s;
        sr_s    = a_mag_s % sdiv_s;
        uq_s    = a / udiv_s;
        ur_s    = a % udiv_s;
    end

    // Result selection by operation.
    always_comb begin
        hi       = 32'd0;
        lo       = 32'd0;
        div_zero = 1'b0;
        case (op)
            HYLO_MULT:  {hi, lo} = sprod_s;
            HYLO_MULTU: {hi, lo} = uprod_s;
            HYLO_DIV: begin
                div_zero = (b == 32'd0);
                lo       = (a[31] ^ b[31]) ? (32'd0 - sq_s) : sq_s;
                hi       = a[31] ? (32'd0 - sr_s) : sr_s;
            end
            HYLO_DIVU: begin
                div_zero = (b == 32'd0);
                lo       = uq_s;
                hi       = ur_s;
            end
            default: begin
                hi       = 32'd0;
                lo       = 32'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage HI/LO multiply/divide unit: issue FSM, busy counter, HI/LO.
// Optional feature macro: MDU_DIV0_TRAP_EN adds the registered divZero pulse.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state_r;
    mdu_state_e  state_nxt_s;
    logic        busy_r;
    logic [3:0]  cnt_r;
    logic [31:0] temp_hi_r;
    logic [31:0] temp_lo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        start_s;
    logic        issue_s;
    logic        is_mult_s;
    logic        commit_s;
    logic        mt_hi_s;
    logic        mt_lo_s;
    logic [31:0] md_out_s;
    logic [31:0] arith_hi_s;
    logic [31:0] arith_lo_s;
    logic        div_zero_s;

    md_arith u_arith (
        .op       (md.hyloOp),
        .a        (md.rsData),
        .b        (md.rtData),
        .hi       (arith_hi_s),
        .lo       (arith_lo_s),
        .div_zero (div_zero_s)
    );

    // State register; busy is kept as its own flop so the output is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MDU_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == MDU_BUSY);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = MDU_IDLE;
        case (state_r)
            MDU_IDLE: begin
                if (issue_s) state_nxt_s = MDU_BUSY;
                else         state_nxt_s = MDU_IDLE;
            end
            MDU_BUSY: begin
                if (cnt_r == 4'd0) state_nxt_s = MDU_IDLE;
                else               state_nxt_s = MDU_BUSY;
            end
            default: state_nxt_s = MDU_IDLE;
        endcase
    end

    // Decode of the E-stage op into issue, move-to and read-back controls.
    always_comb begin
        start_s   = is_md_op(md.hyloOp) && !md.excCancel;
        is_mult_s = (md.hyloOp == HYLO_MULT) || (md.hyloOp == HYLO_MULTU);
        issue_s   = start_s && (state_r == MDU_IDLE);
        commit_s  = (state_r == MDU_BUSY) && (cnt_r == 4'd0);
        mt_hi_s   = (md.hyloOp == HYLO_MTHI) && !md.excCancel && (state_r == MDU_IDLE);
        mt_lo_s   = (md.hyloOp == HYLO_MTLO) && !md.excCancel && (state_r == MDU_IDLE);
        case (md.hyloOp)
            HYLO_MFHI: md_out_s = hi_r;
            HYLO_MFLO: md_out_s = lo_r;
            default:   md_out_s = 32'd0;
        endcase
    end

    // Counter, latched result and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= 4'd0;
            temp_hi_r <= 32'd0;
            temp_lo_r <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            if (issue_s) begin
                cnt_r <= is_mult_s ? MULT_LOAD : DIV_LOAD;
                // A zero divisor re-latches the current HI/LO so the commit is a no-op.
                if (div_zero_s) begin
                    temp_hi_r <= hi_r;
                    temp_lo_r <= lo_r;
                end else begin
                    temp_hi_r <= arith_hi_s;
                    temp_lo_r <= arith_lo_s;
                end
            end else if ((state_r == MDU_BUSY) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (commit_s)     hi_r <= temp_hi_r;
            else if (mt_hi_s) hi_r <= md.rsData;
            else              hi_r <= hi_r;

            if (commit_s)     lo_r <= temp_lo_r;
            else if (mt_lo_s) lo_r <= md.rsData;
            else              lo_r <= lo_r;
        end
    end

`ifdef MDU_DIV0_TRAP_EN
    logic div_zero_r;

    // One-cycle pulse on the edge that issues a divide by zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_zero_r <= 1'b0;
        else       div_zero_r <= issue_s && div_zero_s;
    end

    assign md.divZero = div_zero_r;
`endif

    assign md.start = start_s;
    assign md.busy  = busy_r;
    assign md.hiOut = hi_r;
    assign md.loOut = lo_r;
    assign md.mdOut = md_out_s;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: issue timing, arithmetic results, HI/LO moves,
// divide by zero, exception cancel and mid-operation reset.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   ncyc;

    always #5 clk = ~clk;

    md_unit_if md();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an md op for one cycle, checking start in the issue cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input string tag);
        md.hyloOp = op;
        md.rsData = rs;
        md.rtData = rt;
        #1;
        check({tag, "_start"}, 32'(md.start), 32'd1);
        step();
        md.hyloOp = HYLO_NONE;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (md.busy && cycles < 40) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        reset        = 1'b1;
        md.hyloOp    = HYLO_NONE;
        md.rsData    = 32'd0;
        md.rtData    = 32'd0;
        md.excCancel = 1'b0;
        step();
        step();
        check("rst_busy", 32'(md.busy), 32'd0);
        check("rst_hi", md.hiOut, 32'd0);
        check("rst_lo", md.loOut, 32'd0);
        check("rst_mdout", md.mdOut, 32'd0);
        reset = 1'b0;
        step();

        issue(HYLO_MULT, 32'hFFFF_FFFE, 32'd3, "mult");
        wait_idle(ncyc);
        check("mult_cycles", 32'(ncyc), 32'd5);
        check("mult_hi", md.hiOut, 32'hFFFF_FFFF);
        check("mult_lo", md.loOut, 32'hFFFF_FFFA);

        issue(HYLO_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
        wait_idle(ncyc);
        check("multu_cycles", 32'(ncyc), 32'd5);
        check("multu_hi", md.hiOut, 32'h0000_0002);
        check("multu_lo", md.loOut, 32'hFFFF_FFFA);

        issue(HYLO_DIV, 32'hFFFF_FFF9, 32'd2, "div");
        wait_idle(ncyc);
        check("div_cycles", 32'(ncyc), 32'd10);
        check("div_lo", md.loOut, 32'hFFFF_FFFD);
        check("div_hi", md.hiOut, 32'hFFFF_FFFF);

        issue(HYLO_DIVU, 32'd7, 32'd2, "divu");
        wait_idle(ncyc);
        check("divu_lo", md.loOut, 32'd3);
        check("divu_hi", md.hiOut, 32'd1);

        issue(HYLO_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        wait_idle(ncyc);
        check("divovf_lo", md.loOut, 32'h8000_0000);
        check("divovf_hi", md.hiOut, 32'd0);

        md.hyloOp = HYLO_MTHI;
        md.rsData = 32'h1234_5678;
        #1;
        check("mthi_start", 32'(md.start), 32'd0);
        step();
        md.hyloOp = HYLO_MFHI;
        #1;
        check("mthi_busy", 32'(md.busy), 32'd0);
        check("mthi_hi", md.hiOut, 32'h1234_5678);
        check("mfhi_mdout", md.mdOut, 32'h1234_5678);
        md.hyloOp = HYLO_MFLO;
        #1;
        check("mflo_mdout", md.mdOut, 32'h8000_0000);
        md.hyloOp = HYLO_NONE;
        #1;
        check("none_mdout", md.mdOut, 32'd0);

        md.hyloOp = HYLO_MTLO;
        md.rsData = 32'h0000_000B;
        step();
        md.hyloOp = HYLO_MTHI;
        md.rsData = 32'h0000_000A;
        step();
        md.hyloOp = HYLO_NONE;
        check("mt_lo", md.loOut, 32'h0000_000B);
        check("mt_hi", md.hiOut, 32'h0000_000A);

        issue(HYLO_DIV, 32'h0000_0055, 32'd0, "div0");
`ifdef MDU_DIV0_TRAP_EN
        check("div0_pulse", 32'(md.divZero), 32'd1);
`endif
        wait_idle(ncyc);
`ifdef MDU_DIV0_TRAP_EN
        check("div0_pulse_end", 32'(md.divZero), 32'd0);
`endif
        check("div0_cycles", 32'(ncyc), 32'd10);
        check("div0_hi", md.hiOut, 32'h0000_000A);
        check("div0_lo", md.loOut, 32'h0000_000B);

        md.excCancel = 1'b1;
        md.hyloOp    = HYLO_MULT;
        md.rsData    = 32'd5;
        md.rtData    = 32'd7;
        #1;
        check("cancel_start", 32'(md.start), 32'd0);
        step();
        check("cancel_busy", 32'(md.busy), 32'd0);
        md.hyloOp = HYLO_MTHI;
        md.rsData = 32'h0000_DEAD;
        step();
        md.hyloOp    = HYLO_NONE;
        md.excCancel = 1'b0;
        check("cancel_busy2", 32'(md.busy), 32'd0);
        check("cancel_hi", md.hiOut, 32'h0000_000A);
        check("cancel_lo", md.loOut, 32'h0000_000B);

        issue(HYLO_MULT, 32'd2, 32'd3, "rstmid");
        step();
        step();
        check("rstmid_busy_before", 32'(md.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_busy", 32'(md.busy), 32'd0);
        check("rstmid_hi", md.hiOut, 32'd0);
        check("rstmid_lo", md.loOut, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("rstmid_idle", 32'(md.busy), 32'd0);

        issue(HYLO_MULTU, 32'd6, 32'd7, "after_rst");
        wait_idle(ncyc);
        check("after_rst_cycles", 32'(ncyc), 32'd5);
        check("after_rst_lo", md.loOut, 32'd42);
        check("after_rst_hi", md.hiOut, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide responder for the HI/LO operation code that the instruction decoder emits.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage.
- Runs multi-cycle arithmetic and owns the HI/LO registers.
- Reports start/busy back to the hazard unit, which stalls later md/mt/mf instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1-15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1-15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- hyloOp  in  4  E-stage operation code, HYLO_* encoding from const.v
- rsData  in  32  forwarded rs operand (dividend / multiplicand / mt source)
- rtData  in  32  forwarded rt operand (divisor / multiplier)
- excCancel  in  1  exception or eret in M/W stage this cycle; suppresses issue
- start  out  1  combinational: hyloOp is mult/multu/div/divu and excCancel=0
- busy  out  1  registered: operation in flight
- hiOut  out  32  current HI register
- loOut  out  32  current LO register
- mdOut  out  32  combinational: HI if hyloOp=mfhi, LO if mflo, else 0
- divZero  out  1  divide-by-zero pulse; present only under the optional feature

Behaviour:
- Op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9-15 are treated as NONE.
- Reset (async): state=IDLE, busy=0, cnt=0, HI=0, LO=0, temp=0, divZero=0.
- FSM IDLE:
  - If start, on the next edge: compute result into tempHi/tempLo, cnt<=N-1, busy<=1, state=BUSY.
  - N is MULT_CYCLES for mult/multu and DIV_CYCLES for div/divu.
  - Net effect: busy is high for exactly N cycles after the issue cycle.
- FSM BUSY:
  - Each edge: cnt<=cnt-1.
  - When cnt==0: HI<=tempHi, LO<=tempLo, busy<=0, state=IDLE.
  - New HI/LO become visible in the cycle after busy falls.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; HI=[63:32], LO=[31:0]. multu: same, unsigned.
  - div: LO=signed quotient truncated toward zero, HI=remainder with the dividend's sign. divu: unsigned quotient and remainder.
  - Divisor 0: tempHi/tempLo <= current HI/LO, so HI/LO are unchanged; busy timing is still N cycles.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo:
  - In IDLE with excCancel=0: HI (or LO) <= rsData on the next edge; busy stays 0.
  - While busy or when excCancel=1: ignored. The hazard unit guarantees this never occurs.
- start while busy: ignored; no restart or re-latch. The hazard unit stalls so this never occurs.
- excCancel=1: blocks issue of any op this cycle. An operation already in BUSY runs to completion.
- mfhi/mflo while busy: mdOut returns the old HI/LO. The hazard unit stalls, so this is never consumed.
- Stall contract for the hazard unit: stall D when D holds md/mt/mf and (start|busy).
- Reset mid-operation: abort immediately; HI/LO=0.

Optional Feature:
- Macro MDU_DIV0_TRAP_EN.
- Defined: divZero pulses high for one cycle, registered on the edge after a div/divu issue with rtData==0. HI/LO are unchanged and busy runs N cycles.
- Not defined: no divZero port or logic; divide-by-zero silently leaves HI/LO unchanged.

Decomposition:
- const.v (shared):
  - HYLO_NONE..HYLO_MTLO codes
  - MDU_IDLE/MDU_BUSY state codes
  - default cycle counts
- One sub-module, md_arith: combinational signed/unsigned multiply and divide producing {hi, lo}, plus the divisor-zero flag.
- md_unit holds the FSM, counter, temp registers and HI/LO.

Test Plan:
- mult rs=0xFFFFFFFE, rt=3 -> start=1 in the issue cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu rs=0xFFFFFFFE, rt=3 -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu rs=7, rt=2 -> LO=3, HI=1.
- mthi rs=0x12345678, then mflo/mfhi -> HI=0x12345678 next cycle; mdOut=0x12345678 with hyloOp=MFHI; busy never asserted.
- div rt=0 with HI=0xA, LO=0xB -> after 10 cycles HI=0xA, LO=0xB. With MDU_DIV0_TRAP_EN, divZero=1 for one cycle.
- Cancel and reset cases:
  - mult with excCancel=1 -> busy stays 0, HI/LO unchanged.
  - reset asserted in the 3rd busy cycle of mult -> busy=0, HI=LO=0 immediately.
